// File: rtl/mcu_boot_sequencer.sv
// MCU boot sequencer: waits for a stable PLL lock, then either auto-starts the
// core at a default address or follows hardware-loader hold/start commands.
module mcu_boot_sequencer #(
  parameter int unsigned        XLEN               = 32,
  parameter int unsigned        SETTLE_CYCLES      = 4,
  parameter logic [XLEN-1:0]    DEFAULT_START_ADDR = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pll_lock,
  input  logic            loader_cpu_reset,
  input  logic            loader_cpu_start,
  input  logic [XLEN-1:0] loader_start_addr,
  output logic            mcu_reset_n,
  output logic            cpu_start,
  output logic [XLEN-1:0] cpu_start_addr,
  output logic            sp_init_we,
  output logic [2:0]      boot_state,
  output logic            boot_done
);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    SETTLE     = 3'd1,
    AUTO_START = 3'd2,
    RUN        = 3'd3,
    HELD       = 3'd4,
    IDLE       = 3'd5,
    START_CMD  = 3'd6
  } state_t;

  localparam logic [7:0] SETTLE_LIMIT = 8'(SETTLE_CYCLES);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] settle_cnt;
  logic [7:0] settle_cnt_nxt;

  // Next-state and settle-counter logic; lock loss dominates, then loader hold,
  // then loader start. The counter only carries a value while in SETTLE.
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = '0;
    if (!pll_lock) begin
      state_nxt = WAIT_LOCK;
    end else begin
      case (state)
        WAIT_LOCK: begin
          state_nxt      = SETTLE;
          settle_cnt_nxt = 8'd1;
        end
        SETTLE: begin
          if (loader_cpu_reset) begin
            state_nxt = HELD;
          end else if (settle_cnt == SETTLE_LIMIT) begin
            state_nxt = AUTO_START;
          end else begin
            state_nxt      = SETTLE;
            settle_cnt_nxt = settle_cnt + 8'd1;
          end
        end
        AUTO_START, START_CMD: begin
          state_nxt = loader_cpu_reset ? HELD : RUN;
        end
        RUN, IDLE: begin
          if (loader_cpu_reset) begin
            state_nxt = HELD;
          end else if (loader_cpu_start) begin
            state_nxt = START_CMD;
          end
        end
        HELD: begin
          state_nxt = loader_cpu_reset ? HELD : IDLE;
        end
        default: begin
          state_nxt = WAIT_LOCK;
        end
      endcase
    end
  end

  // State register plus outputs registered as a decode of the next state, so
  // each output lines up with the state it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= WAIT_LOCK;
      settle_cnt     <= '0;
      mcu_reset_n    <= 1'b0;
      cpu_start      <= 1'b0;
      cpu_start_addr <= '0;
      boot_done      <= 1'b0;
    end else begin
      state       <= state_nxt;
      settle_cnt  <= settle_cnt_nxt;
      mcu_reset_n <= !((state_nxt == WAIT_LOCK) || (state_nxt == SETTLE) ||
                       (state_nxt == HELD));
      cpu_start   <= (state_nxt == AUTO_START) || (state_nxt == START_CMD);
      boot_done   <= (state_nxt == RUN);
      if (state_nxt == AUTO_START) begin
        cpu_start_addr <= DEFAULT_START_ADDR;
      end else if (state_nxt == START_CMD) begin
        cpu_start_addr <= loader_start_addr;
      end
    end
  end

  assign sp_init_we = cpu_start;
  assign boot_state = state;

endmodule

// File: tb/tb_mcu_boot_sequencer.sv
// Self-checking bench for mcu_boot_sequencer: directed boot/loader scenarios
// followed by randomized stimulus against a behavioural reference model.
module tb_mcu_boot_sequencer;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned SETTLE_CYCLES = 4;
  localparam logic [31:0] DEF_ADDR      = 32'h8000_0000;

  localparam int P_WAIT   = 0;
  localparam int P_SETTLE = 1;
  localparam int P_AUTO   = 2;
  localparam int P_RUN    = 3;
  localparam int P_HELD   = 4;
  localparam int P_IDLE   = 5;
  localparam int P_CMD    = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pll_lock = 1'b0;
  logic        loader_cpu_reset = 1'b0;
  logic        loader_cpu_start = 1'b0;
  logic [31:0] loader_start_addr = '0;
  logic        mcu_reset_n;
  logic        cpu_start;
  logic [31:0] cpu_start_addr;
  logic        sp_init_we;
  logic [2:0]  boot_state;
  logic        boot_done;

  mcu_boot_sequencer #(
    .XLEN               (XLEN),
    .SETTLE_CYCLES      (SETTLE_CYCLES),
    .DEFAULT_START_ADDR (DEF_ADDR)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pll_lock          (pll_lock),
    .loader_cpu_reset  (loader_cpu_reset),
    .loader_cpu_start  (loader_cpu_start),
    .loader_start_addr (loader_start_addr),
    .mcu_reset_n       (mcu_reset_n),
    .cpu_start         (cpu_start),
    .cpu_start_addr    (cpu_start_addr),
    .sp_init_we        (sp_init_we),
    .boot_state        (boot_state),
    .boot_done         (boot_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: phase, remaining settle cycles, last issued address.
  int          m_phase = P_WAIT;
  int          m_left  = 0;
  logic [31:0] m_addr  = '0;
  logic        prev_start = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_WAIT;
    m_left  = 0;
    m_addr  = '0;
  endtask

  task automatic model_clock();
    int nxt;
    nxt = m_phase;
    if (reset) begin
      model_reset();
      return;
    end
    if (!pll_lock) begin
      nxt = P_WAIT;
    end else begin
      case (m_phase)
        P_WAIT: begin
          nxt    = P_SETTLE;
          m_left = SETTLE_CYCLES - 1;
        end
        P_SETTLE: begin
          if (loader_cpu_reset) nxt = P_HELD;
          else if (m_left == 0) nxt = P_AUTO;
          else m_left = m_left - 1;
        end
        P_AUTO, P_CMD: nxt = loader_cpu_reset ? P_HELD : P_RUN;
        P_RUN, P_IDLE: begin
          if (loader_cpu_reset) begin
            nxt = P_HELD;
          end else if (loader_cpu_start) begin
            nxt    = P_CMD;
            m_addr = loader_start_addr;
          end
        end
        P_HELD: nxt = loader_cpu_reset ? P_HELD : P_IDLE;
        default: nxt = P_WAIT;
      endcase
    end
    if (nxt == P_AUTO) m_addr = DEF_ADDR;
    m_phase = nxt;
  endtask

  task automatic check_outputs();
    logic [2:0] exp_state;
    logic       exp_start;
    exp_state = 3'(m_phase);
    exp_start = (m_phase == P_AUTO) || (m_phase == P_CMD);
    check_eq("boot_state", boot_state, exp_state);
    check_eq("mcu_reset_n", mcu_reset_n,
             !((m_phase == P_WAIT) || (m_phase == P_SETTLE) || (m_phase == P_HELD)));
    check_eq("cpu_start", cpu_start, exp_start);
    check_eq("sp_init_we", sp_init_we, exp_start);
    check_eq("cpu_start_addr", cpu_start_addr, m_addr);
    check_eq("boot_done", boot_done, m_phase == P_RUN);
    check_eq("start_spacing", cpu_start & prev_start, 1'b0);
    prev_start = cpu_start;
  endtask

  task automatic step(input logic lk, input logic lr, input logic ls, input logic [31:0] a);
    pll_lock          = lk;
    loader_cpu_reset  = lr;
    loader_cpu_start  = ls;
    loader_start_addr = a;
    @(posedge clk);
    model_clock();
    #1;
    check_outputs();
  endtask

  // Assert reset between clock edges and expect reset values before the next edge.
  task automatic async_reset_check();
    #2 reset = 1'b1;
    #1;
    model_reset();
    prev_start = 1'b0;
    check_eq("async_rst_state", boot_state, 3'd0);
    check_outputs();
    step(pll_lock, 1'b0, 1'b0, '0);
    reset = 1'b0;
  endtask

  task automatic boot_up();
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < int'(SETTLE_CYCLES) + 3; i++) step(1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int first_pulse;
    int lows;
    int pulses;
    logic lk, lr, ls;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0);
    reset = 1'b0;

    // Power-up: lock rises at cycle 2, auto-start pulse expected 5 cycles later
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    first_pulse = -1;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      if (cpu_start && first_pulse < 0) begin
        first_pulse = 3 + k;
        check_eq("auto_addr", cpu_start_addr, DEF_ADDR);
        check_eq("auto_rstn", mcu_reset_n, 1'b1);
      end
    end
    check_eq("auto_latency", 64'(first_pulse - 2), 64'd5);

    // Lock glitch during settle count 3 restarts the full settle period
    step(1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    first_pulse = -1;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      if (cpu_start && first_pulse < 0) first_pulse = k;
    end
    check_eq("glitch_latency", 64'(first_pulse), 64'(SETTLE_CYCLES + 1));

    // Loader hold for 10 cycles then a loader start at 0x1000
    lows = 0;
    pulses = 0;
    for (int k = 0; k < 11; k++) begin
      step(1'b1, k < 10, 1'b0, '0);
      if (!mcu_reset_n) lows++;
      if (cpu_start) pulses++;
    end
    check_eq("held_low_cycles", 64'(lows), 64'd10);
    check_eq("held_no_start", 64'(pulses), 64'd0);
    step(1'b1, 1'b0, 1'b0, '0);
    check_eq("idle_state", boot_state, 3'd5);
    step(1'b1, 1'b0, 1'b1, 32'h0000_1000);
    check_eq("ldr_start", cpu_start, 1'b1);
    check_eq("ldr_sp_we", sp_init_we, 1'b1);
    check_eq("ldr_addr", cpu_start_addr, 32'h0000_1000);
    step(1'b1, 1'b0, 1'b0, '0);

    // Simultaneous hold+start in RUN, then lock loss with start
    step(1'b1, 1'b1, 1'b1, 32'h1234_5678);
    check_eq("sim_held", boot_state, 3'd4);
    check_eq("sim_no_start", cpu_start, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_2000);
    check_eq("lockloss_state", boot_state, 3'd0);
    check_eq("lockloss_no_start", cpu_start, 1'b0);

    // Back-to-back start requests: only the first produces a pulse
    boot_up();
    step(1'b1, 1'b0, 1'b1, 32'h0000_3000);
    check_eq("b2b_first", cpu_start, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h0000_4000);
    check_eq("b2b_dropped", cpu_start, 1'b0);
    check_eq("b2b_addr_hold", cpu_start_addr, 32'h0000_3000);
    step(1'b1, 1'b0, 1'b0, '0);
    async_reset_check();

    // Randomized phase
    lk = 1'b1;
    lr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) lk = 1'b0;
      else if (!lk && $urandom_range(0, 2) == 0) lk = 1'b1;
      if ($urandom_range(0, 19) == 0) lr = !lr;
      ls = ($urandom_range(0, 3) == 0);
      step(lk, lr, ls, $urandom);
      if ($urandom_range(0, 299) == 0) async_reset_check();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcu_boot_sequencer.md
MCU_BOOT_SEQUENCER -- requirements
Module: mcu_boot_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: consecutive cycles pll_lock must be high before the auto-start; legal range 1..255.
REQ-002 Parameter DEFAULT_START_ADDR, default 32'h8000_0000: program counter used for the auto-start.
REQ-003 Parameter XLEN, default 32: address width.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pll_lock  input  1  PLL lock indication, synchronous to clk.
REQ-007 loader_cpu_reset  input  1  hardware-loader request to hold the MCU in reset, level.
REQ-008 loader_cpu_start  input  1  hardware-loader start request, single-cycle pulse.
REQ-009 loader_start_addr  input  XLEN  start address; valid only while loader_cpu_start=1.
REQ-010 mcu_reset_n  output  1  active-low reset to the MCU core, registered.
REQ-011 cpu_start  output  1  single-cycle start pulse to the MCU, registered.
REQ-012 cpu_start_addr  output  XLEN  start address; valid whenever cpu_start=1.
REQ-013 sp_init_we  output  1  stack-pointer initialise strobe; equals cpu_start every cycle.
REQ-014 boot_state  output  3  current FSM state encoding, for LEDs and debug.
REQ-015 boot_done  output  1  high while in RUN.

Function
REQ-016 The FSM SHALL have the states WAIT_LOCK=0, SETTLE=1, AUTO_START=2, RUN=3, HELD=4, IDLE=5 and START_CMD=6; encoding 7 is unused and SHALL return to WAIT_LOCK.
REQ-017 Transition priority every cycle: pll_lock=0 first, then loader_cpu_reset=1, then loader_cpu_start=1.
REQ-018 pll_lock=0 in any state SHALL cause WAIT_LOCK on the next cycle and clear the settle counter.
REQ-019 WAIT_LOCK: pll_lock=1 -> SETTLE with the counter at 1.
REQ-020 SETTLE: the 8-bit counter SHALL increment each cycle lock stays high; when it equals SETTLE_CYCLES -> AUTO_START.
REQ-021 AUTO_START: lasts exactly 1 cycle, then -> RUN.
REQ-022 RUN or IDLE: loader_cpu_reset=1 -> HELD; otherwise loader_cpu_start=1 -> START_CMD and loader_start_addr is captured.
REQ-023 loader_cpu_reset=1 in SETTLE or AUTO_START SHALL go to HELD, cancelling the auto-start.
REQ-024 HELD: loader_cpu_start is ignored; loader_cpu_reset=0 -> IDLE, with no auto-start.
REQ-025 START_CMD: lasts exactly 1 cycle, then -> RUN.
REQ-026 mcu_reset_n SHALL be 0 in WAIT_LOCK, SETTLE and HELD, and 1 in all other states; it is a registered decode of the next state.
REQ-027 cpu_start SHALL be 1 exactly in the cycle the FSM is in AUTO_START or START_CMD.
REQ-028 Start latency: a loader_cpu_start pulse in cycle N SHALL give cpu_start=1 in cycle N+1, with cpu_start_addr equal to the address captured in cycle N.
REQ-029 cpu_start_addr SHALL equal DEFAULT_START_ADDR during AUTO_START and hold its last value while cpu_start=0.
REQ-030 loader_cpu_start in START_CMD or AUTO_START SHALL be dropped; there is no queuing.
REQ-031 At most one cpu_start pulse SHALL occur in any two consecutive cycles.

Reset
REQ-032 While reset=1 (asynchronous assert, synchronous release): state=WAIT_LOCK, counter=0, mcu_reset_n=0, cpu_start=0, sp_init_we=0, cpu_start_addr=0, boot_done=0, boot_state=0.
REQ-033 Reset asserted mid-operation SHALL override every state in the same cycle, including a cpu_start pulse in progress.

Verification
REQ-034 Power-up with SETTLE_CYCLES=4: release reset, pll_lock=1 at cycle 2 -> one cpu_start pulse 5 cycles later with addr 8000_0000, mcu_reset_n=1 from that cycle, boot_done=1 next cycle.
REQ-035 Lock glitch: pll_lock drops for 1 cycle during SETTLE count 3 -> counter restarts, auto-start delayed by the full SETTLE_CYCLES.
REQ-036 Loader sequence from RUN: loader_cpu_reset high 10 cycles -> mcu_reset_n low 10 cycles, then IDLE with no start; loader_cpu_start with addr 0000_1000 -> cpu_start and sp_init_we one cycle later, addr 0000_1000.
REQ-037 Simultaneous events: loader_cpu_reset=1 and loader_cpu_start=1 in RUN -> HELD, no cpu_start; pll_lock=0 with loader_cpu_start=1 -> WAIT_LOCK, no pulse.
REQ-038 Back-to-back start pulses in cycles N and N+1 -> single cpu_start in N+1; second request dropped; then reset asserted mid-RUN -> all outputs at reset values immediately.
